// File: rtl/select_issue_16.sv
// select_issue_16: index-to-select issuer.
// Accepts 5-bit port indices into a small circular FIFO and presents the head
// as a one-hot 16-bit select vector. Index values 16..31 mean "no port" and
// are normalised to 16 on entry.
// Optional feature macro: SELECT_ISSUE_DROP_NULL_EN. When defined, null
// indices complete the handshake but are never stored.
//
// Handshake: a beat transfers on a rising edge when valid && ready are both
// high. Valid never waits on ready. The producer holds in_valid/in_idx until
// it sees in_ready. The consumer may raise out_ready at any time. All outputs
// come from registers only, so in_ready and out_valid never depend
// combinationally on in_valid or out_ready.
module select_issue_16 #(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [4:0]    in_idx,
  output logic          in_ready,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [15:0]   select,
  output logic [4:0]    out_idx,
  output logic [CW-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [4:0] NULL_IDX = 5'd16;

  logic [4:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [4:0]    norm_idx;
  logic [4:0]    head;
  logic          accept;
  logic          push;
  logic          pop;

  // Normalise the incoming index and decide whether an accepted beat is stored
  always_comb begin
    norm_idx = in_idx[4] ? NULL_IDX : in_idx;
    accept   = in_valid && in_ready;
`ifdef SELECT_ISSUE_DROP_NULL_EN
    // Null beats are consumed from the producer but never occupy a slot
    push     = accept && !in_idx[4];
`else
    // Null beats are stored and later issued as a bubble slot
    push     = accept;
`endif
    pop      = out_valid && out_ready;
  end

  // Status and head presentation, all derived from registered state
  always_comb begin
    in_ready  = (count < CW'(DEPTH));
    out_valid = (count != '0);
    head      = mem[rd_ptr];
    out_idx   = out_valid ? head : NULL_IDX;
    select    = '0;
    if (out_valid && !head[4]) begin
      select = 16'b1 << head[3:0];
    end
  end

  // Pointer and occupancy registers; reset discards all entries at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage array; contents are only meaningful below the occupancy count
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= norm_idx;
    end
  end

endmodule

// File: tb/tb_select_issue_16.sv
// Testbench for select_issue_16: directed steps plus randomized traffic,
// checked against a queue-based model of the FIFO behaviour.
module tb_select_issue_16;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;
`ifdef SELECT_ISSUE_DROP_NULL_EN
  localparam bit DROP = 1'b1;
`else
  localparam bit DROP = 1'b0;
`endif

  // Clock and reset
  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic [4:0]    in_idx;
  logic          in_ready;
  logic          out_valid;
  logic          out_ready;
  logic [15:0]   select;
  logic [4:0]    out_idx;
  logic [CW-1:0] count;

  always #5 clk = ~clk;

  select_issue_16 #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_idx    (in_idx),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .select    (select),
    .out_idx   (out_idx),
    .count     (count)
  );

  // Scoreboard: expected FIFO contents, head at index 0
  logic [4:0] exp_q[$];
  int tests  = 0;
  int failed = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Compare every output against the model's current state
  task automatic check_outputs(input string tag);
    logic [4:0]  h;
    logic [31:0] sel;
    h   = (exp_q.size() != 0) ? exp_q[0] : 5'd16;
    sel = (exp_q.size() != 0 && h < 5'd16) ? (32'd1 << h) : 32'd0;
    chk({tag, ":count"},     32'(count),     32'(exp_q.size()));
    chk({tag, ":in_ready"},  32'(in_ready),  32'(exp_q.size() < DEPTH));
    chk({tag, ":out_valid"}, 32'(out_valid), 32'(exp_q.size() != 0));
    chk({tag, ":out_idx"},   32'(out_idx),   32'(h));
    chk({tag, ":select"},    32'(select),    sel);
  endtask

  // Driver: apply inputs for one cycle, check, then advance model and clock
  task automatic step(input bit iv, input logic [4:0] ii, input bit ordy, input string tag);
    bit acc;
    bit pop;
    in_valid  = iv;
    in_idx    = ii;
    out_ready = ordy;
    check_outputs(tag);
    acc = iv && (exp_q.size() < DEPTH);
    pop = ordy && (exp_q.size() != 0);
    if (pop) void'(exp_q.pop_front());
    if (acc && !(DROP && ii >= 5'd16)) exp_q.push_back((ii >= 5'd16) ? 5'd16 : ii);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int peak;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_idx    = 5'd0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Reset then idle
    check_outputs("reset");
    step(0, 5'd0, 0, "idle0");
    step(0, 5'd0, 1, "idle1");

    // Back-to-back 3, 15, 0 with consumer ready
    step(1, 5'd3, 1, "b2b_push3");
    chk("b2b_sel3", 32'(select), 32'h0008);
    step(1, 5'd15, 1, "b2b_push15");
    chk("b2b_sel15", 32'(select), 32'h8000);
    step(1, 5'd0, 1, "b2b_push0");
    chk("b2b_sel0", 32'(select), 32'h0001);
    step(0, 5'd0, 1, "b2b_drain");
    chk("b2b_empty", 32'(out_valid), 32'd0);

    // Fill past capacity with consumer stalled
    for (int i = 1; i <= 5; i++) step(1, 5'(i), 0, "fill");
    chk("full_count", 32'(count), 32'd4);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    chk("full_head", 32'(out_idx), 32'd1);
    // Stalled outputs hold
    step(0, 5'd0, 0, "stall");
    chk("stall_head", 32'(select), 32'h0002);

    // Full with push and pop both offered: pop only
    step(1, 5'd9, 1, "full_pp");
    chk("after_full_pp_count", 32'(count), 32'd3);
    chk("after_full_pp_ready", 32'(in_ready), 32'd1);
    step(1, 5'd10, 1, "pp3");
    chk("pp3_count", 32'(count), 32'd3);
    for (int i = 0; i < 4; i++) step(0, 5'd0, 1, "drain");
    chk("drained", 32'(count), 32'd0);

    // Simultaneous push and pop at count 1
    step(1, 5'd4, 0, "c1_push");
    step(1, 5'd6, 1, "c1_pp");
    chk("c1_count", 32'(count), 32'd1);
    chk("c1_head", 32'(out_idx), 32'd6);
    step(0, 5'd0, 1, "c1_drain");

    // Null index followed by 7
    step(1, 5'd20, 1, "null_push");
    if (DROP) begin
      chk("null_dropped_valid", 32'(out_valid), 32'd0);
    end else begin
      chk("null_beat_valid", 32'(out_valid), 32'd1);
      chk("null_beat_select", 32'(select), 32'd0);
      chk("null_beat_idx", 32'(out_idx), 32'd16);
    end
    step(1, 5'd7, 1, "seven_push");
    chk("seven_select", 32'(select), 32'h0080);
    chk("seven_count", 32'(count), 32'd1);
    step(0, 5'd0, 1, "seven_drain");

    // Randomized traffic with varying consumer readiness
    peak = 0;
    for (int ph = 0; ph < 3; ph++) begin
      for (int i = 0; i < 200; i++) begin
        bit iv;
        bit ordy;
        iv   = ($urandom_range(0, 3) != 0);
        ordy = (ph == 0) ? 1'b1 : (ph == 1) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 1) == 1);
        step(iv, 5'($urandom_range(0, 31)), ordy, "rand");
        if (exp_q.size() > peak) peak = exp_q.size();
      end
    end
    for (int i = 0; i < DEPTH + 1; i++) step(0, 5'd0, 1, "rand_drain");

    // Asynchronous reset mid-stream with two entries held
    step(1, 5'd5, 0, "pre_rst_a");
    step(1, 5'd9, 0, "pre_rst_b");
    chk("pre_rst_count", 32'(count), 32'd2);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    check_outputs("async_rst");
    @(posedge clk);
    #1;
    check_outputs("in_rst");
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) step(0, 5'd0, 1, "post_rst");
    step(1, 5'd12, 1, "post_rst_push");
    chk("post_rst_sel", 32'(select), 32'h1000);
    step(0, 5'd0, 1, "post_rst_drain");
    check_outputs("final");

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  // Watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    failed++;
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
